dmi_reg_bridge: RTL
===================

# dmi_reg_bridge

Core-clock DMI responder that terminates the core side of the JTAG-to-core DMI clock-domain crossing. It accepts `dm::dmi_req_t` requests over a valid/ready handshake and converts READ/WRITE operations into accesses on a simple req/gnt/rvalid register bus. It returns one `dm::dmi_resp_t` per request, holding it stable under back-pressure. A bus timeout guarantees that every request is answered, so a hung target cannot stall the debug link.

## Interface
Parameters:
- `TimeoutCycles`, 255: maximum cycles spent in REQ+WAIT before an error response is returned. 0 disables the timeout.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  asynchronous active-low reset
- `dmi_req_i`  in  `$bits(dm::dmi_req_t)`  request: `addr[6:0]`, `op[1:0]`, `data[31:0]`
- `dmi_req_valid_i`  in  1  request valid
- `dmi_req_ready_o`  out  1  request accepted when high with valid
- `dmi_resp_o`  out  `$bits(dm::dmi_resp_t)`  response: `data[31:0]`, `resp[1:0]`
- `dmi_resp_valid_o`  out  1  response valid
- `dmi_resp_ready_i`  in  1  response consumed
- `reg_req_o`  out  1  bus request
- `reg_we_o`  out  1  1 = write
- `reg_addr_o`  out  7  register address
- `reg_wdata_o`  out  32  write data
- `reg_gnt_i`  in  1  request granted
- `reg_rvalid_i`  in  1  access complete, one cycle pulse
- `reg_rdata_i`  in  32  read data, valid with rvalid
- `reg_err_i`  in  1  access error, valid with rvalid

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are driven from registered state.
- **IDLE.** `dmi_req_ready_o`=1. On valid&ready, addr/op/data are captured. Next state depends on op:
  - NOP (0): RESP with data=0, resp=SUCCESS (0).
  - READ (1) or WRITE (2): REQ.
  - op=3: RESP with data=0, resp=ERR (2).
- **REQ.** `reg_req_o`=1. `reg_we_o`=(op==WRITE). addr and wdata are held stable until `reg_gnt_i`. On gnt: WAIT.
- **WAIT.** On `reg_rvalid_i`: RESP.
  - resp = `reg_err_i` ? ERR : SUCCESS.
  - data = rdata for READ without error; otherwise 0.
- **Timeout.** The counter is cleared on entering REQ and increments each cycle in REQ or WAIT. In the cycle where the count equals TimeoutCycles-1 with no gnt (REQ) or rvalid (WAIT), the next state is RESP with resp=ERR and data=0.
  - Completion wins over timeout in the same cycle.
  - Counter width is `$clog2(TimeoutCycles+1)`.
- **Stale response.** A timeout taken from WAIT sets `stale_q`. The next `reg_rvalid_i` seen in any state is discarded and clears `stale_q`; it never completes a transaction. Targets respond in order.
- **RESP.** `dmi_resp_valid_o`=1. `dmi_resp_o` is stable until `dmi_resp_ready_i`, then the FSM returns to IDLE.
- There is never more than one outstanding DMI transaction. `dmi_req_ready_o`=0 in every state except IDLE.
- `reg_req_o` outside REQ: 0. addr/wdata outputs hold their last captured values.

## Timing
- Reset values: state=IDLE, `dmi_req_ready_o`=1, `dmi_resp_valid_o`=0, `dmi_resp_o`=0, `reg_req_o`=0, `reg_we_o`=0, `reg_addr_o`=0, `reg_wdata_o`=0, counter=0, `stale_q`=0.
- NOP or op=3 accepted in cycle 0: response valid in cycle 1. Ready returns in the cycle after the response handshake.
- READ accepted in cycle 0: `reg_req_o` high from cycle 1. With gnt in cycle 1 and rvalid in cycle 2, response is valid in cycle 3.
- `reg_rvalid_i` is never expected in the same cycle as its own gnt; any such pulse is ignored.
- Back-pressure: with `dmi_resp_ready_i`=0, the response is held indefinitely and no new request is accepted.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight response is lost and `stale_q` is cleared.

## Test plan
- NOP with `dmi_resp_ready_i`=1: response {data=0, resp=0} is valid exactly one cycle after accept; ready is high again one cycle later.
- READ addr 0x04, gnt after 2 cycles, rvalid with rdata=0xDEADBEEF and err=0: bus shows req=1, we=0, addr=0x04 held until gnt; response {0xDEADBEEF, 0}.
- WRITE addr 0x10 data 0x12345678 with err=1 on rvalid, and resp_ready held low for 5 cycles: we=1, wdata=0x12345678; response {0, 2} stable for all 5 cycles; no new request accepted during that time.
- TimeoutCycles=8, gnt never asserted: `reg_req_o` is high exactly 8 cycles, then response {0, 2}. Repeat with gnt, then no rvalid: response {0, 2}; a late rvalid with 0xAAAA5555 is dropped; the next READ returns its own rdata.
- op=3 returns {0, 2} with no bus activity. A reset pulse asserted while in WAIT returns all outputs to reset values, and the next NOP completes normally.

Source files
------------

// File: rtl/dmi_reg_bridge.sv
// Core-side DMI responder: turns DMI READ/WRITE requests into req/gnt/rvalid
// register-bus accesses, with a bus timeout so every request gets a response.

package dm;
  localparam logic [1:0] DTM_NOP     = 2'h0;
  localparam logic [1:0] DTM_READ    = 2'h1;
  localparam logic [1:0] DTM_WRITE   = 2'h2;
  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_reg_bridge #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dm::dmi_req_t  dmi_req_i,
  input  logic          dmi_req_valid_i,
  output logic          dmi_req_ready_o,
  output dm::dmi_resp_t dmi_resp_o,
  output logic          dmi_resp_valid_o,
  input  logic          dmi_resp_ready_i,
  output logic          reg_req_o,
  output logic          reg_we_o,
  output logic [6:0]    reg_addr_o,
  output logic [31:0]   reg_wdata_o,
  input  logic          reg_gnt_i,
  input  logic          reg_rvalid_i,
  input  logic [31:0]   reg_rdata_i,
  input  logic          reg_err_i
);

  localparam bit          TimeoutEn = (TimeoutCycles > 0);
  localparam int unsigned CntW      = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  dm::dmi_resp_t resp_q, resp_d;
  logic          reg_req_q, reg_req_d;
  logic          reg_we_q, reg_we_d;
  logic [6:0]    reg_addr_q, reg_addr_d;
  logic [31:0]   reg_wdata_q, reg_wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          stale_q, stale_d;

  logic            rvalid_live_s;
  logic            timeout_s;
  logic [CntW-1:0] cnt_inc_s;

  // A pulse owed to a timed-out access must never complete a later transaction.
  assign rvalid_live_s = reg_rvalid_i & ~stale_q;
  assign timeout_s     = TimeoutEn && (cnt_q == CntLast);
  assign cnt_inc_s     = TimeoutEn ? (cnt_q + CntW'(1)) : cnt_q;

  // Next-state and next-output computation.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    reg_req_d    = reg_req_q;
    reg_we_d     = reg_we_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    cnt_d        = cnt_q;

    if (reg_rvalid_i && stale_q) begin
      stale_d = 1'b0;
    end else begin
      stale_d = stale_q;
    end

    case (state_q)
      IDLE: begin
        if (dmi_req_valid_i && req_ready_q) begin
          op_d        = dmi_req_i.op;
          reg_addr_d  = dmi_req_i.addr;
          reg_wdata_d = dmi_req_i.data;
          req_ready_d = 1'b0;
          case (dmi_req_i.op)
            dm::DTM_NOP: begin
              state_d      = RESP;
              resp_valid_d = 1'b1;
              resp_d.data  = 32'h0;
              resp_d.resp  = dm::DTM_SUCCESS;
            end
            dm::DTM_READ, dm::DTM_WRITE: begin
              state_d   = REQ;
              reg_req_d = 1'b1;
              reg_we_d  = (dmi_req_i.op == dm::DTM_WRITE);
              cnt_d     = '0;
            end
            default: begin
              state_d      = RESP;
              resp_valid_d = 1'b1;
              resp_d.data  = 32'h0;
              resp_d.resp  = dm::DTM_ERR;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        if (reg_gnt_i) begin
          state_d   = WAIT;
          reg_req_d = 1'b0;
          cnt_d     = cnt_inc_s;
        end else if (timeout_s) begin
          state_d      = RESP;
          reg_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_d.data  = 32'h0;
          resp_d.resp  = dm::DTM_ERR;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end

      WAIT: begin
        if (rvalid_live_s) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_d.resp  = reg_err_i ? dm::DTM_ERR : dm::DTM_SUCCESS;
          resp_d.data  = ((op_q == dm::DTM_READ) && !reg_err_i) ? reg_rdata_i : 32'h0;
        end else if (timeout_s) begin
          // The target still owes a pulse for this access; drop it when it arrives.
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_d.data  = 32'h0;
          resp_d.resp  = dm::DTM_ERR;
          stale_d      = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end

      RESP: begin
        if (dmi_resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        reg_req_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      op_q         <= 2'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      reg_req_q    <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= 7'h0;
      reg_wdata_q  <= 32'h0;
      cnt_q        <= '0;
      stale_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      reg_req_q    <= reg_req_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      cnt_q        <= cnt_d;
      stale_q      <= stale_d;
    end
  end

  assign dmi_req_ready_o  = req_ready_q;
  assign dmi_resp_o       = resp_q;
  assign dmi_resp_valid_o = resp_valid_q;
  assign reg_req_o        = reg_req_q;
  assign reg_we_o         = reg_we_q;
  assign reg_addr_o       = reg_addr_q;
  assign reg_wdata_o      = reg_wdata_q;

endmodule
